// File: rtl/wb_sched_if.sv
// Bundles the write-source, issue, busy-check and register-file write
// signals around the writeback scheduler.
interface wb_sched_if;
  logic        pipe_we;
  logic [4:0]  pipe_w;
  logic [31:0] pipe_din;
  logic        mdu_valid;
  logic [4:0]  mdu_w;
  logic [31:0] mdu_din;
  logic        mdu_ready;
  logic        iss_valid;
  logic [4:0]  iss_w;
  logic [4:0]  A;
  logic [4:0]  B;
  logic        busyA;
  logic        busyB;
  logic        hold;
  logic        RFWr;
  logic [4:0]  W;
  logic [31:0] din;

  modport master (
    output pipe_we, pipe_w, pipe_din, mdu_valid, mdu_w, mdu_din,
           iss_valid, iss_w, A, B,
    input  mdu_ready, busyA, busyB, hold, RFWr, W, din
  );

  modport slave (
    input  pipe_we, pipe_w, pipe_din, mdu_valid, mdu_w, mdu_din,
           iss_valid, iss_w, A, B,
    output mdu_ready, busyA, busyB, hold, RFWr, W, din
  );
endinterface

// File: rtl/wb_sched.sv
// Writeback scheduler: merges the pipeline WB stage and buffered MDU results
// onto the single register-file write port and tracks pending MDU writes.
module wb_sched #(
  parameter int DEPTH      = 4,
  parameter int AW         = 2,
  parameter int STARVE_MAX = 8
) (
  input logic        clk,
  input logic        rst,
  wb_sched_if.slave  bus
);
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [4:0]    fifo_w [DEPTH];
  logic [31:0]   fifo_d [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [31:0]   pending;
  logic [31:0]   pending_nxt;
  logic [SW-1:0] starve;

  logic       empty;
  logic       full;
  logic       pslot;
  logic       pop;
  logic       push;
  logic [4:0] head_w;

  assign empty  = (count == '0);
  assign full   = (count == (AW+1)'(DEPTH));
  assign head_w = fifo_w[rd_ptr];
  assign pslot  = !rst && bus.pipe_we && (bus.pipe_w != 5'd0);
  assign pop    = !rst && !pslot && !empty;
  assign push   = bus.mdu_valid && bus.mdu_ready && (bus.mdu_w != 5'd0);

  assign bus.mdu_ready = !rst && !full;
  assign bus.busyA = pending[bus.A] && !(pop && head_w == bus.A);
  assign bus.busyB = pending[bus.B] && !(pop && head_w == bus.B);
  assign bus.hold  = pslot && !empty && (starve >= SW'(STARVE_MAX - 1));

  always_comb begin
    bus.RFWr = 1'b0;
    bus.W    = 5'd0;
    bus.din  = 32'd0;
    if (pslot) begin
      bus.RFWr = 1'b1;
      bus.W    = bus.pipe_w;
      bus.din  = bus.pipe_din;
    end else if (pop) begin
      bus.RFWr = 1'b1;
      bus.W    = head_w;
      bus.din  = fifo_d[rd_ptr];
    end
  end

  // An issue and a head write to the same register in one cycle leave it pending.
  always_comb begin
    pending_nxt = pending;
    if (pop)
      pending_nxt[head_w] = 1'b0;
    if (bus.iss_valid && bus.iss_w != 5'd0)
      pending_nxt[bus.iss_w] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_w[wr_ptr] <= bus.mdu_w;
      fifo_d[wr_ptr] <= bus.mdu_din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      pending <= '0;
      starve  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
      pending <= pending_nxt;
      if (pop || empty)
        starve <= '0;
      else if (pslot && starve != SW'(STARVE_MAX))
        starve <= starve + 1'b1;
    end
  end
endmodule

// File: tb/tb_wb_sched.sv
// Directed bench for wb_sched: a cycle-by-cycle vector table plus hand-written
// sequences for reset, starvation/hold, set-wins and pointer wrap.
module tb_wb_sched;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  wb_sched_if bus ();
  wb_sched dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    bit        pwe;  bit [4:0] pw; bit [31:0] pd;
    bit        mv;   bit [4:0] mw; bit [31:0] md;
    bit        iv;   bit [4:0] iw;
    bit [4:0]  a;    bit [4:0] b;
    bit        rfwr; bit [4:0] w;  bit [31:0] d;
    bit        rdy;  bit ba; bit bb; bit hold;
  } vec_t;

  vec_t vecs [15];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.pipe_we = 0; bus.pipe_w = 0; bus.pipe_din = 0;
    bus.mdu_valid = 0; bus.mdu_w = 0; bus.mdu_din = 0;
    bus.iss_valid = 0; bus.iss_w = 0; bus.A = 0; bus.B = 0;
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.pipe_we = v.pwe; bus.pipe_w = v.pw; bus.pipe_din = v.pd;
    bus.mdu_valid = v.mv; bus.mdu_w = v.mw; bus.mdu_din = v.md;
    bus.iss_valid = v.iv; bus.iss_w = v.iw; bus.A = v.a; bus.B = v.b;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Decode must never let the pipeline overwrite a register still owed by the MDU.
  always @(negedge clk) begin
    if (!rst && bus.pipe_we && bus.pipe_w != 5'd0 && dut.pending[bus.pipe_w]) begin
      failures++;
      $display("[TB] FAIL waw_protocol: pipe write to pending r%0d", bus.pipe_w);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0]  = '{0,0,0,          0,0,0,             0,0,  0,0,   0,0,0,            1,0,0,0};
    vecs[1]  = '{0,0,0,          0,0,0,             1,5,  5,0,   0,0,0,            1,0,0,0};
    vecs[2]  = '{0,0,0,          1,5,32'hDEADBEEF,  0,0,  5,0,   0,0,0,            1,1,0,0};
    vecs[3]  = '{0,0,0,          0,0,0,             0,0,  5,0,   1,5,32'hDEADBEEF, 1,0,0,0};
    vecs[4]  = '{0,0,0,          0,0,0,             0,0,  5,0,   0,0,0,            1,0,0,0};
    vecs[5]  = '{1,3,32'h33,     1,7,32'h77,        1,7,  7,3,   1,3,32'h33,       1,0,0,0};
    vecs[6]  = '{0,0,0,          0,0,0,             0,0,  7,7,   1,7,32'h77,       1,0,0,0};
    vecs[7]  = '{0,0,0,          0,0,0,             0,0,  7,7,   0,0,0,            1,0,0,0};
    vecs[8]  = '{1,0,32'h55,     1,0,32'h99,        0,0,  0,0,   0,0,0,            1,0,0,0};
    vecs[9]  = '{0,0,0,          0,0,0,             0,0,  0,0,   0,0,0,            1,0,0,0};
    vecs[10] = '{0,0,0,          0,0,0,             1,12, 12,12, 0,0,0,            1,0,0,0};
    vecs[11] = '{1,4,32'h44,     1,12,32'hC,        0,0,  12,12, 1,4,32'h44,       1,1,1,0};
    vecs[12] = '{1,4,32'h45,     0,0,0,             0,0,  12,12, 1,4,32'h45,       1,1,1,0};
    vecs[13] = '{0,0,0,          0,0,0,             0,0,  12,12, 1,12,32'hC,       1,0,0,0};
    vecs[14] = '{0,0,0,          0,0,0,             0,0,  12,12, 0,0,0,            1,0,0,0};

    idle();
    rst = 1'b1;
    step();
    @(negedge clk);
    checkOutput("reset_rfwr", bus.RFWr, 0);
    checkOutput("reset_ready", bus.mdu_ready, 0);
    @(posedge clk); #1 rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("v%0d_rfwr", i),  bus.RFWr,      vecs[i].rfwr);
      checkOutput($sformatf("v%0d_w", i),     bus.W,         vecs[i].w);
      checkOutput($sformatf("v%0d_din", i),   bus.din,       vecs[i].d);
      checkOutput($sformatf("v%0d_ready", i), bus.mdu_ready, vecs[i].rdy);
      checkOutput($sformatf("v%0d_busyA", i), bus.busyA,     vecs[i].ba);
      checkOutput($sformatf("v%0d_busyB", i), bus.busyB,     vecs[i].bb);
      checkOutput($sformatf("v%0d_hold", i),  bus.hold,      vecs[i].hold);
      step();
    end
    idle();
    checkOutput("table_pending", dut.pending, 0);
    checkOutput("table_count", dut.count, 0);

    // Reset in the middle of operation with three entries queued.
    for (int i = 0; i < 3; i++) begin
      bus.pipe_we = 1; bus.pipe_w = 1; bus.pipe_din = i;
      bus.mdu_valid = 1; bus.mdu_w = 5'(20 + i); bus.mdu_din = i;
      bus.iss_valid = 1; bus.iss_w = 5'(20 + i);
      step();
    end
    bus.mdu_valid = 0; bus.iss_valid = 0; bus.A = 20;
    checkOutput("rst_pre_count", dut.count, 3);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_rfwr", bus.RFWr, 0);
    checkOutput("rst_w", bus.W, 0);
    checkOutput("rst_din", bus.din, 0);
    checkOutput("rst_ready", bus.mdu_ready, 0);
    checkOutput("rst_hold", bus.hold, 0);
    checkOutput("rst_busyA", bus.busyA, 0);
    checkOutput("rst_count", dut.count, 0);
    checkOutput("rst_pending", dut.pending, 0);
    idle();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_rel_ready", bus.mdu_ready, 1);
    checkOutput("rst_rel_rfwr", bus.RFWr, 0);
    step();

    // Fill the FIFO under continuous pipeline writes until hold forces a bubble.
    for (int j = 0; j < 9; j++) begin
      bus.pipe_we = 1; bus.pipe_w = 1; bus.pipe_din = j;
      bus.mdu_valid = (j < 4); bus.mdu_w = 5'(24 + j); bus.mdu_din = 32'h100 + j;
      @(negedge clk);
      if (j < 4) checkOutput($sformatf("fill%0d_ready", j), bus.mdu_ready, 1);
      if (j == 4) checkOutput("full_ready", bus.mdu_ready, 0);
      if (j == 5) checkOutput("starve_w", bus.W, 1);
      if (j == 7) checkOutput("hold_c7", bus.hold, 0);
      if (j == 8) checkOutput("hold_c8", bus.hold, 1);
      step();
    end
    bus.pipe_we = 0; bus.mdu_valid = 1; bus.mdu_w = 28; bus.mdu_din = 32'h108;
    @(negedge clk);
    checkOutput("bubble_ready", bus.mdu_ready, 0);
    checkOutput("bubble_rfwr", bus.RFWr, 1);
    checkOutput("bubble_w", bus.W, 24);
    checkOutput("bubble_din", bus.din, 32'h100);
    checkOutput("bubble_hold", bus.hold, 0);
    step();
    @(negedge clk);
    checkOutput("pushpop_ready", bus.mdu_ready, 1);
    checkOutput("pushpop_w", bus.W, 25);
    checkOutput("pushpop_din", bus.din, 32'h101);
    step();
    idle();
    checkOutput("pushpop_count", dut.count, 3);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput($sformatf("drain%0d_w", k), bus.W, (k == 2) ? 28 : 26 + k);
      checkOutput($sformatf("drain%0d_din", k), bus.din, (k == 2) ? 32'h108 : 32'h102 + k);
      step();
    end
    @(negedge clk);
    checkOutput("drained_rfwr", bus.RFWr, 0);

    // Issue to a register in the same cycle its older result is written.
    bus.iss_valid = 1; bus.iss_w = 9; bus.A = 9;
    step();
    bus.iss_valid = 0; bus.mdu_valid = 1; bus.mdu_w = 9; bus.mdu_din = 32'h999;
    @(negedge clk);
    checkOutput("sw_busy_wait", bus.busyA, 1);
    step();
    bus.mdu_valid = 0; bus.iss_valid = 1; bus.iss_w = 9;
    @(negedge clk);
    checkOutput("sw_w", bus.W, 9);
    checkOutput("sw_bypass_busy", bus.busyA, 0);
    step();
    bus.iss_valid = 0;
    @(negedge clk);
    checkOutput("sw_set_wins", bus.busyA, 1);
    checkOutput("sw_rfwr", bus.RFWr, 0);
    step();
    bus.mdu_valid = 1; bus.mdu_w = 9; bus.mdu_din = 32'h998;
    step();
    bus.mdu_valid = 0;
    @(negedge clk);
    checkOutput("sw2_din", bus.din, 32'h998);
    step();
    @(negedge clk);
    checkOutput("sw_cleared", bus.busyA, 0);
    idle();

    // Back-to-back pushes wrap both pointers twice; writes must keep push order.
    for (int k = 0; k < 9; k++) begin
      bus.mdu_valid = (k < 8); bus.mdu_w = 5'(10 + k); bus.mdu_din = 32'hA0 + k;
      @(negedge clk);
      if (k > 0) begin
        checkOutput($sformatf("wrap%0d_w", k), bus.W, 10 + k - 1);
        checkOutput($sformatf("wrap%0d_din", k), bus.din, 32'hA0 + k - 1);
      end
      step();
    end
    idle();
    checkOutput("wrap_count", dut.count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end
endmodule
